// File: rtl/fir_lms_pkg.sv
// fir_lms_pkg: shared FSM state encoding and width helper for the LMS adaptive FIR
package fir_lms_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILT = 2'd1, ERR = 2'd2, UPD = 2'd3} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/lms_mac.sv
// lms_mac: signed W1xW1 multiply, sign-extended to WA bits, optionally added to acc
module lms_mac #(
  parameter int W1 = 8,
  parameter int WA = 18
) (
  input  logic [W1-1:0] a,
  input  logic [W1-1:0] b,
  input  logic [WA-1:0] acc,
  input  logic          acc_en,
  output logic [WA-1:0] sum
);
  logic signed [2*W1-1:0] prod;
  assign prod = $signed(a) * $signed(b);
  assign sum = (acc_en ? acc : '0) + WA'(prod);
endmodule

// File: rtl/fir_lms_pipe.sv
// fir_lms_pipe: time-multiplexed L-tap LMS adaptive FIR; define FIR_LMS_SAT_EN to saturate coefficient updates instead of wrapping
module fir_lms_pipe import fir_lms_pkg::*; #(
  parameter int W1 = 8,
  parameter int L = 4,
  parameter int MU_SHIFT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W1-1:0]       x_in,
  input  logic [W1-1:0]       d_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                adapt_en,
  input  logic                coef_clr,
  input  logic [clog2(L)-1:0] coef_sel,
  output logic [W1-1:0]       coef_out,
  output logic [2*W1-1:0]     y_out,
  output logic [2*W1-1:0]     e_out,
  output logic                out_valid
);
  localparam int W2 = 2 * W1;
  localparam int KW = clog2(L);
  localparam int WA = W2 + KW;
  state_t state;
  logic [KW-1:0] k;
  logic [W1-1:0] x [L];
  logic [W1-1:0] f [L];
  logic [W1-1:0] d, emu, delta, f_new;
  logic adapt, accept, last, unused_bits;
  logic [WA-1:0] acc, mac_sum;
  logic [W2-1:0] upd_sum, y, ys, e;
  assign in_ready = state == IDLE;
  assign accept = in_valid & in_ready;
  assign last = k == KW'(L - 1);
  assign coef_out = f[coef_sel];
  assign y = acc[W2-1:0];
  assign ys = $signed(y) >>> (W1 - 1);
  assign e = {{W1{d[W1-1]}}, d} - ys;
  assign delta = upd_sum[W2-1:W1];
  assign unused_bits = ^upd_sum[W1-1:0];
  lms_mac #(.W1(W1), .WA(WA)) u_filt (.a(x[k]), .b(f[k]), .acc(acc), .acc_en(1'b1), .sum(mac_sum));
  lms_mac #(.W1(W1), .WA(W2)) u_upd (.a(emu), .b(x[k]), .acc('0), .acc_en(1'b0), .sum(upd_sum));
`ifdef FIR_LMS_SAT_EN
  logic [W1:0] f_sum;
  assign f_sum = {f[k][W1-1], f[k]} + {delta[W1-1], delta};
  assign f_new = f_sum[W1] == f_sum[W1-1] ? f_sum[W1-1:0] : {f_sum[W1], {(W1-1){~f_sum[W1]}}};
`else
  assign f_new = f[k] + delta;
`endif
  // sequencer: walks taps through FILT and UPD, pulses out_valid after ERR
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= state == ERR;
      k <= (state == FILT || state == UPD) && !last ? k + KW'(1) : '0;
      case (state)
        IDLE: state <= accept ? FILT : IDLE;
        FILT: state <= last ? ERR : FILT;
        ERR: state <= adapt ? UPD : IDLE;
        default: state <= last ? IDLE : UPD;
      endcase
    end
  end
  // sample path: delay line, accumulation, error and scaled error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) x[i] <= '0;
      d <= '0;
      adapt <= 1'b0;
      acc <= '0;
      emu <= '0;
      y_out <= '0;
      e_out <= '0;
    end else begin
      if (accept) begin
        x[0] <= x_in;
        for (int i = 1; i < L; i++) x[i] <= x[i-1];
        d <= d_in;
        adapt <= adapt_en;
        acc <= '0;
      end
      if (state == FILT) acc <= mac_sum;
      if (state == ERR) begin
        y_out <= y;
        e_out <= e;
        emu <= W1'($signed(e) >>> MU_SHIFT);
      end
    end
  end
  // coefficient bank: clear only while idle, otherwise one tap per UPD cycle
  always_ff @(posedge clk) begin
    if (reset || (in_ready && coef_clr)) for (int i = 0; i < L; i++) f[i] <= '0;
    else if (state == UPD) f[k] <= f_new;
  end
endmodule

// File: tb/tb_fir_lms_pipe.sv
// tb_fir_lms_pipe: randomized and directed checks of fir_lms_pipe against an arithmetic LMS model
module tb_fir_lms_pipe;
  localparam int W1 = 8, L = 4, MU_SHIFT = 1;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, adapt_en = 1'b0, coef_clr = 1'b0;
  logic [W1-1:0] x_in = '0, d_in = '0, coef_out;
  logic [1:0] coef_sel = '0;
  logic in_ready, out_valid;
  logic [2*W1-1:0] y_out, e_out;
  int checks = 0, errors = 0;
  int xm [L];
  int fm [L];
  int qy[$], qe[$];
  always #5 clk = ~clk;
  fir_lms_pipe #(.W1(W1), .L(L), .MU_SHIFT(MU_SHIFT)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .adapt_en(adapt_en), .coef_clr(coef_clr), .coef_sel(coef_sel), .coef_out(coef_out),
    .y_out(y_out), .e_out(e_out), .out_valid(out_valid)
  );
  function automatic int wrap(input int v, input int w);
    int m;
    m = v & ((1 << w) - 1);
    return m >= (1 << (w - 1)) ? m - (1 << w) : m;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic model_accept(input int xv, input int dv, input bit a, input bit c);
    int y, e, emu, nf;
    for (int k = L - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = xv;
    if (c) for (int k = 0; k < L; k++) fm[k] = 0;
    y = 0;
    for (int k = 0; k < L; k++) y += xm[k] * fm[k];
    y = wrap(y, 2 * W1);
    e = wrap(dv - (y >>> (W1 - 1)), 2 * W1);
    qy.push_back(y);
    qe.push_back(e);
    if (a) begin
      emu = wrap(e >>> MU_SHIFT, W1);
      for (int k = 0; k < L; k++) begin
        nf = fm[k] + ((emu * xm[k]) >>> W1);
`ifdef FIR_LMS_SAT_EN
        fm[k] = nf > 127 ? 127 : nf < -128 ? -128 : nf;
`else
        fm[k] = wrap(nf, W1);
`endif
      end
    end
  endtask
  // compare process: every out_valid pulse must match the next model result
  always @(negedge clk) begin
    if (out_valid) begin
      if (qy.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_valid: got unexpected pulse, expected none");
      end else begin
        chk("y_out", $signed(y_out), qy.pop_front());
        chk("e_out", $signed(e_out), qe.pop_front());
      end
    end
  end
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    coef_clr = 1'b0;
    adapt_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < L; k++) begin
      xm[k] = 0;
      fm[k] = 0;
    end
    qy.delete();
    qe.delete();
  endtask
  task automatic check_coefs(input string tag);
    for (int k = 0; k < L; k++) begin
      coef_sel = 2'(k);
      #1 chk($sformatf("%s f[%0d]", tag, k), $signed(coef_out), fm[k]);
    end
  endtask
  task automatic send(input int xv, input int dv, input bit a, input bit c, input bit noise);
    int n, ov_n, rdy_n, lim;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    x_in = W1'(xv);
    d_in = W1'(dv);
    adapt_en = a;
    coef_clr = c;
    in_valid = 1'b1;
    @(posedge clk);
    model_accept(xv, dv, a, c);
    #1 in_valid = 1'b0;
    coef_clr = 1'b0;
    ov_n = 0;
    rdy_n = 0;
    lim = a ? 2 * L + 1 : L + 1;
    for (n = 1; n <= 3 * L + 4 && rdy_n == 0; n++) begin
      @(negedge clk);
      if (out_valid && ov_n == 0) ov_n = n;
      if (in_ready) rdy_n = n;
      in_valid = noise && n <= lim;
      coef_clr = noise && n <= lim;
      if (noise) begin
        x_in = W1'($urandom);
        d_in = W1'($urandom);
        adapt_en = 1'b1;
      end
    end
    in_valid = 1'b0;
    coef_clr = 1'b0;
    chk("out_valid cycle", ov_n, L + 2);
    chk("in_ready cycle", rdy_n, a ? 2 * L + 2 : L + 2);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int ov_cnt, f0, minf, ev;
    bit went_neg, wrapped;
    do_reset();
    chk("reset in_ready", in_ready, 1);
    chk("reset y_out", $signed(y_out), 0);
    chk("reset e_out", $signed(e_out), 0);
    chk("reset out_valid", out_valid, 0);
    for (int k = 0; k < L; k++) begin
      coef_sel = 2'(k);
      #1 chk("reset coef", $signed(coef_out), 0);
    end
    send(64, 64, 1'b1, 1'b0, 1'b0);
    chk("first y_out", $signed(y_out), 0);
    chk("first e_out", $signed(e_out), 64);
    chk("model f0 after first", fm[0], 8);
    coef_sel = 2'd0;
    #1 chk("first coef0", $signed(coef_out), 8);
    for (int k = 1; k < L; k++) begin
      coef_sel = 2'(k);
      #1 chk("first coef other", $signed(coef_out), 0);
    end
    do_reset();
    send(64, 64, 1'b0, 1'b0, 1'b0);
    chk("noadapt e_out", $signed(e_out), 64);
    for (int k = 0; k < L; k++) begin
      coef_sel = 2'(k);
      #1 chk("noadapt coef", $signed(coef_out), 0);
    end
    do_reset();
    send(64, 64, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    x_in = 8'd100;
    d_in = 8'd50;
    adapt_en = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort in_ready", in_ready, 1);
    for (int k = 0; k < L; k++) begin
      xm[k] = 0;
      fm[k] = 0;
    end
    ov_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("abort out_valid count", ov_cnt, 0);
    for (int k = 0; k < L; k++) begin
      coef_sel = 2'(k);
      #1 chk("abort coef", $signed(coef_out), 0);
    end
    do_reset();
    send(64, 64, 1'b1, 1'b0, 1'b0);
    send(64, 100, 1'b0, 1'b1, 1'b0);
    chk("clr+accept y_out", $signed(y_out), 0);
    chk("clr+accept e_out", $signed(e_out), 100);
    check_coefs("clr");
    do_reset();
    for (int i = 0; i < 60; i++) begin
      send($signed(W1'($urandom)), $signed(W1'($urandom)), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      check_coefs("rand");
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send(i % 2 ? -64 : 64, i % 2 ? -32 : 32, 1'b1, 1'b0, 1'b0);
      ev = $signed(e_out);
      if (i >= 180) chk("converged |e|<=2", int'(ev <= 2 && ev >= -2), 1);
    end
    check_coefs("converged");
    do_reset();
    went_neg = 1'b0;
    wrapped = 1'b0;
    minf = 0;
    f0 = 0;
    for (int i = 0; i < 100; i++) begin
      send(-16, 127, 1'b1, 1'b0, 1'b0);
      coef_sel = 2'd0;
      #1 f0 = $signed(coef_out);
      if (f0 < minf) minf = f0;
      if (f0 < 0) went_neg = 1'b1;
      if (went_neg && f0 > 0) wrapped = 1'b1;
    end
    check_coefs("drive");
`ifdef FIR_LMS_SAT_EN
    chk("sat f0 final", f0, -128);
    chk("sat f0 min", minf, -128);
    chk("sat no wrap", int'(wrapped), 0);
`else
    chk("wrap f0 went positive", int'(wrapped), 1);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
